// File: rtl/spi_master_cpha0.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_cpha0
// Description : Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//               Bytes arrive on a valid/ready handshake. tx_last closes the
//               frame; otherwise ssel stays low and the next byte is awaited.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV  : clk cycles per sck half-period (2..255)
//   IDLE_GAP : clk cycles ssel stays high after a frame (1..255)
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   tx_data  : byte to transmit
//   tx_valid : tx_data / tx_last valid
//   tx_last  : release ssel after this byte
//   tx_ready : byte accepted when tx_valid is also high
//   rx_data  : byte received from miso
//   rx_valid : one-cycle strobe qualifying rx_data
//   busy     : state machine not idle
//   sck      : SPI clock (registered, idle low)
//   mosi     : serial data out (registered)
//   miso     : serial data in
//   ssel     : slave select, active low (registered)
// ============================================================================
module spi_master_cpha0 #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_NEXT  = 3'd4,
        S_TRAIL = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] C_GAP_LAST = 8'(IDLE_GAP - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [2:0] r_bitcnt;
    logic [6:0] r_tx_shift;   // bits still to be sent; bit 7 goes straight to mosi
    logic [6:0] r_rx_shift;   // bits already received this byte
    logic       r_last;
    logic       r_sck;
    logic       r_mosi;
    logic       r_ssel;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic       w_handshake;
    logic       w_div_done;
    logic [7:0] w_rx_next;

    assign tx_ready    = (r_state == S_IDLE) || (r_state == S_NEXT);
    assign busy        = (r_state != S_IDLE);
    assign w_handshake = tx_valid & tx_ready;
    assign w_div_done  = (r_div == C_DIV_LAST);
    assign w_rx_next   = {r_rx_shift, miso};

    assign sck      = r_sck;
    assign mosi     = r_mosi;
    assign ssel     = r_ssel;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bitcnt   <= 3'd0;
            r_tx_shift <= 7'd0;
            r_rx_shift <= 7'd0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ssel     <= 1'b1;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_NEXT: begin
                    r_sck <= 1'b0;
                    if (w_handshake) begin
                        r_tx_shift <= tx_data[6:0];
                        r_last     <= tx_last;
                        r_mosi     <= tx_data[7];
                        r_ssel     <= 1'b0;
                        r_div      <= 8'd0;
                        r_state    <= S_LEAD;
                    end
                end
                S_LEAD, S_LOW: begin
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_div_done) begin
                        // Sample as late as possible in the high phase so a
                        // slave with synchronizer latency has settled miso.
                        r_div      <= 8'd0;
                        r_sck      <= 1'b0;
                        r_rx_shift <= w_rx_next[6:0];
                        if (r_bitcnt != 3'd7) begin
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            r_mosi     <= r_tx_shift[6];
                            r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            r_state    <= S_LOW;
                        end else begin
                            r_bitcnt   <= 3'd0;
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= r_last ? S_TRAIL : S_NEXT;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_TRAIL: begin
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_ssel  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_div == C_GAP_LAST) begin
                        r_div   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cpha0.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_cpha0
// Description : Directed self-checking bench for spi_master_cpha0. Instance A
//               uses CLK_DIV=4 with miso looped back to mosi; instance B uses
//               CLK_DIV=2 with miso tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_cpha0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
    logic       tx_valid_a = 1'b0;
    logic       tx_valid_b = 1'b0;

    logic       tx_ready_a, rx_valid_a, busy_a, sck_a, mosi_a, ssel_a, miso_a;
    logic [7:0] rx_data_a;
    logic       tx_ready_b, rx_valid_b, busy_b, sck_b, mosi_b, ssel_b;
    logic       miso_b = 1'b1;
    logic [7:0] rx_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign miso_a = mosi_a;

    spi_master_cpha0 #(.CLK_DIV(4), .IDLE_GAP(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_a),
        .tx_last(tx_last), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .busy(busy_a), .sck(sck_a), .mosi(mosi_a),
        .miso(miso_a), .ssel(ssel_a)
    );

    spi_master_cpha0 #(.CLK_DIV(2), .IDLE_GAP(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_b),
        .tx_last(tx_last), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .busy(busy_b), .sck(sck_b), .mosi(mosi_b),
        .miso(miso_b), .ssel(ssel_b)
    );

    // ---------------- bus monitors (sample on falling clk edge) -------------
    int          a_edges = 0, a_since = 0, a_period = 0, a_rxv = 0;
    int          a_low_run = 0, a_low_len = 0, a_rises = 0;
    int          a_gap_run = 0, a_gap_len = 0, a_rdy_hi = 0;
    logic [31:0] a_bits = 0;
    logic [7:0]  a_rx_last = 0, a_rx_prev = 0;
    logic        a_prev_sck = 0, a_prev_ssel = 1, a_prev_busy = 0;

    always @(negedge clk) begin
        a_since++;
        if (sck_a && !a_prev_sck) begin
            a_edges++;
            a_bits   = {a_bits[30:0], mosi_a};
            a_period = a_since;
            a_since  = 0;
        end
        a_prev_sck = sck_a;
        if (rx_valid_a) begin
            a_rxv++;
            a_rx_prev = a_rx_last;
            a_rx_last = rx_data_a;
        end
        if (!ssel_a) a_low_run++;
        else begin
            if (a_low_run != 0) a_low_len = a_low_run;
            a_low_run = 0;
        end
        if (ssel_a && !a_prev_ssel) a_rises++;
        a_prev_ssel = ssel_a;
        if (ssel_a && busy_a) a_gap_run++;
        else if (!busy_a && a_prev_busy) begin
            a_gap_len = a_gap_run;
            a_gap_run = 0;
        end
        a_prev_busy = busy_a;
        if (sck_a && tx_ready_a) a_rdy_hi++;
    end

    int          b_edges = 0, b_since = 0, b_period = 0, b_low_run = 0, b_low_len = 0;
    logic [31:0] b_bits = 0;
    logic [7:0]  b_rx_last = 0;
    logic        b_prev_sck = 0;

    always @(negedge clk) begin
        b_since++;
        if (sck_b && !b_prev_sck) begin
            b_edges++;
            b_bits   = {b_bits[30:0], mosi_b};
            b_period = b_since;
            b_since  = 0;
        end
        b_prev_sck = sck_b;
        if (rx_valid_b) b_rx_last = rx_data_b;
        if (!ssel_b) b_low_run++;
        else begin
            if (b_low_run != 0) b_low_len = b_low_run;
            b_low_run = 0;
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        tx_data = d;
        tx_last = last;
        if (sel) tx_valid_b = 1'b1; else tx_valid_a = 1'b1;
        while (!(sel ? tx_ready_b : tx_ready_a) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_ready_timeout", sel ? tx_ready_b : tx_ready_a, 1);
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sel ? busy_b : busy_a) && n < 3000);
        if (n >= 3000) check("idle_timeout", sel ? busy_b : busy_a, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int base_e, base_r, base_s, n, stall_bad;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ssel", ssel_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_data", rx_data_a, 8'h00);
        check("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", tx_ready_a, 1);

        // Single byte 0xA5, loopback
        base_e = a_edges; base_r = a_rxv;
        send(0, 8'hA5, 1);
        wait_idle(0);
        check("a5_edges", a_edges - base_e, 8);
        check("a5_mosi_bits", a_bits[7:0], 8'hA5);
        check("a5_rx_data", a_rx_last, 8'hA5);
        check("a5_rx_pulses", a_rxv - base_r, 1);
        check("a5_ssel_low", a_low_len, 68);
        check("a5_gap", a_gap_len, 2);
        check("a5_sck_period", a_period, 8);

        // Back-to-back 0x3C then 0xC3
        base_e = a_edges; base_r = a_rxv; base_s = a_rises;
        send(0, 8'h3C, 0);
        send(0, 8'hC3, 1);
        n = 0;
        while ((a_edges - base_e) < 9 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("b2b_interbyte_period", a_period, 9);
        wait_idle(0);
        check("b2b_edges", a_edges - base_e, 16);
        check("b2b_mosi_bits", a_bits[15:0], 16'h3CC3);
        check("b2b_rx_pulses", a_rxv - base_r, 2);
        check("b2b_rx_first", a_rx_prev, 8'h3C);
        check("b2b_rx_second", a_rx_last, 8'hC3);
        check("b2b_ssel_rises", a_rises - base_s, 1);

        // 0x80, 20-cycle stall in NEXT, then 0x01
        base_e = a_edges; base_s = a_rises;
        send(0, 8'h80, 0);
        n = 0;
        while (!(busy_a && tx_ready_a) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("stall_reach_next", busy_a && tx_ready_a, 1);
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ssel_a || sck_a || !tx_ready_a) stall_bad++;
        end
        check("stall_lines", stall_bad, 0);
        send(0, 8'h01, 1);
        wait_idle(0);
        check("stall_edges", a_edges - base_e, 16);
        check("stall_rx_first", a_rx_prev, 8'h80);
        check("stall_rx_second", a_rx_last, 8'h01);
        check("stall_ssel_rises", a_rises - base_s, 1);

        // tx_valid during GAP is ignored
        base_e = a_edges;
        send(0, 8'h66, 1);
        n = 0;
        while (!(ssel_a && busy_a) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        tx_data = 8'hFF; tx_last = 1'b1; tx_valid_a = 1'b1;
        #1;
        check("gap_ready_low", tx_ready_a, 0);
        @(posedge clk); #1;
        tx_valid_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("gap_no_accept", busy_a, 0);
        check("gap_edges", a_edges - base_e, 8);
        check("gap_rx_data", a_rx_last, 8'h66);
        check("ready_during_sck_high", a_rdy_hi, 0);

        // Reset after the 3rd rising edge of a byte
        base_e = a_edges; base_r = a_rxv;
        send(0, 8'h96, 1);
        n = 0;
        while ((a_edges - base_e) < 3 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        #1 rst_n = 1'b0;
        #1;
        check("abort_ssel", ssel_a, 1);
        check("abort_sck", sck_a, 0);
        check("abort_mosi", mosi_a, 0);
        check("abort_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", tx_ready_a, 1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_rx", a_rxv - base_r, 0);
        base_e = a_edges;
        send(0, 8'h5A, 1);
        wait_idle(0);
        check("after_abort_rx", a_rx_last, 8'h5A);
        check("after_abort_edges", a_edges - base_e, 8);

        // CLK_DIV=2, miso tied high, byte 0x00
        base_e = b_edges;
        send(1, 8'h00, 1);
        wait_idle(1);
        check("div2_rx", b_rx_last, 8'hFF);
        check("div2_period", b_period, 4);
        check("div2_edges", b_edges - base_e, 8);
        check("div2_mosi_bits", b_bits[7:0], 8'h00);
        check("div2_ssel_low", b_low_len, 34);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_master_cpha0.md
SPI_MASTER_CPHA0 -- requirements
Module: spi_master_cpha0

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per sck half-period; legal range 2..255.
REQ-002 SHALL have parameter IDLE_GAP, default 2: clk cycles ssel is held high after a frame before the next byte is accepted; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-006 SHALL have port tx_valid  input  1  tx_data/tx_last are valid.
REQ-007 SHALL have port tx_last  input  1  deassert ssel after this byte.
REQ-008 SHALL have port tx_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port rx_data  output  8  byte shifted in from miso.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port sck  output  1  SPI clock, registered; idle low (CPOL=0).
REQ-013 SHALL have port mosi  output  1  serial data out, registered.
REQ-014 SHALL have port miso  input  1  serial data in.
REQ-015 SHALL have port ssel  output  1  slave select, active low, registered.

Function
REQ-016 SHALL implement states IDLE, LEAD, HIGH, LOW, NEXT, TRAIL and GAP; the divider counts 0..CLK_DIV-1 inside LEAD, HIGH, LOW and TRAIL.
REQ-017 SHALL drive tx_ready high only in IDLE and NEXT; a handshake is tx_valid & tx_ready in the same cycle.
REQ-018 IDLE: ssel=1, sck=0; on handshake, latch tx_data/tx_last, drive ssel=0 and mosi=tx_data[7], go to LEAD.
REQ-019 LEAD: sck=0 for CLK_DIV cycles with mosi stable, then drive sck=1 and go to HIGH (this is the rising edge).
REQ-020 HIGH: sck=1 for CLK_DIV cycles; miso SHALL be sampled into the receive shift register on the last HIGH cycle, to tolerate slave input-synchronizer latency.
REQ-021 At the end of HIGH with bitcnt<7: drive sck=0, shift the next bit onto mosi on the falling edge, increment bitcnt, go to LOW.
REQ-022 LOW: sck=0 for CLK_DIV cycles, then drive sck=1 and go to HIGH.
REQ-023 At the end of HIGH with bitcnt==7: drive sck=0, load rx_data, pulse rx_valid for exactly 1 cycle, reset bitcnt to 0.
REQ-024 On that same end of HIGH: go to TRAIL if the latched last flag is 1, else go to NEXT.
REQ-025 NEXT: ssel=0, sck=0, wait indefinitely; on handshake, latch the byte, drive mosi=bit7, go to LEAD.
REQ-026 Minimum sck-low time between bytes is therefore 1+CLK_DIV cycles.
REQ-027 TRAIL: ssel=0, sck=0 for CLK_DIV cycles, then drive ssel=1 and go to GAP.
REQ-028 GAP: ssel=1 for IDLE_GAP cycles, then go to IDLE.
REQ-029 SHALL ignore tx_valid outside IDLE and NEXT; latched data SHALL NOT change mid-byte.
REQ-030 Per byte: exactly 8 sck rising edges; sck period is 2*CLK_DIV; one frame with N bytes has 8N rising edges.
REQ-031 sck, mosi and ssel SHALL change only on clk edges and SHALL be glitch-free.

Reset
REQ-032 While rst_n=0, and from any state including mid-byte, SHALL immediately force state=IDLE, ssel=1, sck=0, mosi=0, rx_valid=0, rx_data=0x00, busy=0, bitcnt=0, divider=0.
REQ-033 tx_ready SHALL be 1 from the first cycle after reset release; no rx_valid SHALL be produced for an aborted byte.

Verification
REQ-034 CLK_DIV=4, miso looped to mosi, single byte 0xA5 with last=1 -> mosi bits 1,0,1,0,0,1,0,1 at rising edges; rx_data=0xA5; one rx_valid pulse; ssel low 68 cycles; ssel high IDLE_GAP cycles before tx_ready.
REQ-035 Back-to-back 0x3C (last=0) then 0xC3 (last=1), tx_valid held -> ssel stays low throughout; 16 rising edges; rx_valid pulses carry 0x3C then 0xC3.
REQ-036 Byte 0x80 (last=0), then tx_valid low for 20 cycles, then 0x01 (last=1) -> ssel stays low and sck stays low during the stall; tx_ready high in NEXT; frame completes normally.
REQ-037 rst_n pulsed low after the 3rd rising edge of a byte -> same cycle: ssel=1, sck=0, mosi=0; no rx_valid; a following 0x5A transfer is correct.
REQ-038 CLK_DIV=2, miso tied 1, byte 0x00 with last=1 -> sck period 4 cycles; rx_data=0xFF.
REQ-039 tx_valid asserted during GAP and during HIGH -> not accepted (tx_ready=0); latched data unchanged.
